// File: rtl/mips_mc_controller_p.sv
// Multicycle MIPS control FSM with memory wait-state handshake, optional memory
// timeout, illegal-instruction trap, and cycle / retired-instruction counters.
module mips_mc_controller_p #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 0,
    parameter int TO_W        = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [5:0]       opcode_i,
    input  logic [5:0]       funct_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             pc_write_cond_o,
    output logic             iord_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             ir_write_o,
    output logic             reg_write_o,
    output logic             alu_src_a_o,
    output logic [1:0]       reg_dst_o,
    output logic [1:0]       mem_to_reg_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       pc_src_o,
    output logic [2:0]       alu_op_o,
    output logic             illegal_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] retired_cnt_o,
    output logic [3:0]       state_o
);

    // state  | meaning
    // FETCH  | read instruction at PC, PC <= PC+4 when memory ready
    // DECODE | branch target into ALUOut, dispatch on opcode
    // MEMADR | compute lw/sw effective address
    // MEMRD  | data read, waits for mem_ready
    // MEMWB  | load data into rt
    // MEMWR  | data write, waits for mem_ready
    // EXEC   | R-type ALU operation
    // RWB    | R-type result into rd
    // BRANCH | beq/bne compare and conditional PC update
    // JUMP   | j
    // JAL    | jal: PC <= target, $31 <= PC
    // IEXEC  | addi/slti ALU operation
    // IWB    | immediate result into rt
    // TRAP   | illegal instruction or memory timeout, held until reset
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_JAL    = 4'd10,
        S_IEXEC  = 4'd11,
        S_IWB    = 4'd12,
        S_TRAP   = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam bit TO_EN = (MEM_TIMEOUT > 0);
    // Timeout fires during the MEM_TIMEOUT-th consecutive low cycle, i.e. when
    // MEM_TIMEOUT-1 low cycles have already been counted.
    localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(MEM_TIMEOUT - 1) : '0;

    state_e           state_q, state_d;
    logic [TO_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;
    logic             mem_err_q, mem_err_d;

    logic             mem_wait;
    logic             timeout_hit;
    logic             retire;
    logic             set_illegal;
    logic             funct_ok;
    logic [2:0]       funct_alu;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct_i)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    assign mem_wait    = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                         && !mem_ready_i;
    assign timeout_hit = TO_EN && mem_wait && (wait_q == TO_LAST);

    // State register and bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            cycle_q   <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            cycle_q   <= cycle_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        set_illegal = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (timeout_hit)      state_d = S_TRAP;
                else if (mem_ready_i) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode_i)
                    OP_RTYPE:        state_d = S_EXEC;
                    OP_LW, OP_SW:    state_d = S_MEMADR;
                    OP_BEQ, OP_BNE:  state_d = S_BRANCH;
                    OP_J:            state_d = S_JUMP;
                    OP_JAL:          state_d = S_JAL;
                    OP_ADDI, OP_SLTI: state_d = S_IEXEC;
                    default: begin
                        state_d     = S_TRAP;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready_i)      state_d = S_MEMWB;
                else if (timeout_hit) state_d = S_TRAP;
            end
            S_MEMWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEMWR: begin
                if (mem_ready_i) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                end
            end
            S_EXEC: begin
                if (funct_ok) begin
                    state_d = S_RWB;
                end else begin
                    state_d     = S_TRAP;
                    set_illegal = 1'b1;
                end
            end
            S_RWB, S_BRANCH, S_JUMP, S_JAL, S_IWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_IEXEC: state_d = S_IWB;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        wait_d    = (mem_wait && (state_d == state_q)) ? wait_q + 1'b1 : '0;
        cycle_d   = (state_q != S_TRAP) ? cycle_q + 1'b1 : cycle_q;
        retired_d = retire ? retired_q + 1'b1 : retired_q;
        illegal_d = illegal_q | set_illegal;
        mem_err_d = mem_err_q | timeout_hit;
    end

    // Output logic
    always_comb begin
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        iord_o          = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        reg_dst_o       = 2'd0;
        mem_to_reg_o    = 2'd0;
        alu_src_b_o     = 2'd0;
        pc_src_o        = 2'd0;
        alu_op_o        = ALU_AND;
        case (state_q)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'd1;
                alu_op_o    = ALU_ADD;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            S_DECODE: begin
                alu_src_b_o = 2'd3;
                alu_op_o    = ALU_ADD;
            end
            S_MEMADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'd2;
                alu_op_o    = ALU_ADD;
            end
            S_MEMRD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg_o = 2'd1;
                reg_write_o  = 1'b1;
            end
            S_MEMWR: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = funct_ok ? funct_alu : ALU_AND;
            end
            S_RWB: begin
                reg_dst_o   = 2'd1;
                reg_write_o = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = ALU_SUB;
                pc_src_o        = 2'd1;
                pc_write_cond_o = (opcode_i == OP_BNE) ? !zero_i : zero_i;
            end
            S_JUMP: begin
                pc_src_o   = 2'd2;
                pc_write_o = 1'b1;
            end
            S_JAL: begin
                pc_src_o     = 2'd2;
                pc_write_o   = 1'b1;
                reg_dst_o    = 2'd2;
                mem_to_reg_o = 2'd2;
                reg_write_o  = 1'b1;
            end
            S_IEXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'd2;
                alu_op_o    = (opcode_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            S_IWB: begin
                reg_write_o = 1'b1;
            end
            default: ;
        endcase
        // Architectural write strobes must stay quiet for the whole reset pulse
        if (!rst_ni) begin
            pc_write_o  = 1'b0;
            ir_write_o  = 1'b0;
            reg_write_o = 1'b0;
            mem_write_o = 1'b0;
        end
    end

    assign illegal_o     = illegal_q;
    assign mem_err_o     = mem_err_q;
    assign cycle_cnt_o   = cycle_q;
    assign retired_cnt_o = retired_q;
    assign state_o       = state_q;

endmodule
